// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order feature map.
// One pooled pixel is emitted per 2x2 window through a registered valid/ready output stage.
module maxpool_2x2_stream #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_BITS-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [DATA_BITS-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_done
);

  localparam int unsigned HalfW = IMG_W / 2;
  localparam int unsigned ColW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned LbW   = (HalfW > 1) ? $clog2(HalfW) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  typedef logic signed [DATA_BITS-1:0] pix_t;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  pix_t            hreg_q, hreg_d;
  pix_t            out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_done_q, frame_done_d;

  // Line buffer holds the horizontal maxima of the even row; no reset needed.
  pix_t            lb_q [HalfW];

  logic            in_xfer, out_xfer;
  logic            col_odd, row_odd, col_wrap, frame_end;
  logic            lb_we, res_load;
  logic [LbW-1:0]  lb_idx;
  pix_t            hmax, lb_rd, vmax;

  assign in_ready  = ~out_valid_q | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;

  assign col_odd   = col_q[0];
  assign row_odd   = row_q[0];
  assign col_wrap  = (col_q == ColLast);
  assign frame_end = col_wrap & (row_q == RowLast);

  assign lb_idx    = LbW'(col_q >> 1);
  assign lb_rd     = lb_q[lb_idx];

  // Ties resolve toward the newer operand; the value is identical either way.
  assign hmax      = (in_data >= hreg_q) ? in_data : hreg_q;
  assign vmax      = (hmax >= lb_rd) ? hmax : lb_rd;

  assign lb_we     = in_xfer & col_odd & ~row_odd;
  assign res_load  = in_xfer & col_odd & row_odd;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hreg_d       = hreg_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;

    if (in_xfer) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      if (!col_odd) begin
        hreg_d = in_data;
      end
      frame_done_d = frame_end;
    end

    // A new result overrides the clear so a same-cycle drain and load keeps valid high.
    if (res_load) begin
      out_valid_d = 1'b1;
      out_data_d  = vmax;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hreg_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hreg_q       <= hreg_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= hmax;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
